// File: rtl/mat_vect_mult_par.sv
// Multi-lane matrix-vector multiplier: loads a COLS-element vector, then streams a
// row-major ROWS x COLS matrix (LANES elements per beat) and emits one dot-product per row.
module mat_vect_mult_par #(
  parameter int unsigned ROWS   = 4,
  parameter int unsigned COLS   = 4,
  parameter int unsigned LANES  = 2,
  parameter int unsigned DW     = 8,
  parameter bit          SIGNED = 1'b0,
  localparam int unsigned OW    = 2*DW + $clog2(COLS)
) (
  input  logic                aclk,
  input  logic                aresetn,
  input  logic [DW-1:0]       v_axis_tdata,
  input  logic                v_axis_tvalid,
  output logic                v_axis_tready,
  input  logic [LANES*DW-1:0] s_axis_tdata,
  input  logic                s_axis_tvalid,
  input  logic                s_axis_tlast,
  output logic                s_axis_tready,
  output logic [OW-1:0]       m_axis_tdata,
  output logic                m_axis_tvalid,
  output logic                m_axis_tlast,
  input  logic                m_axis_tready,
  input  logic                reuse_vec,
  output logic                err
);

  localparam int unsigned VIW   = $clog2(COLS);
  localparam int unsigned BEATS = COLS / LANES;
  localparam int unsigned BTW   = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam int unsigned RW    = (ROWS > 1) ? $clog2(ROWS) : 1;

  typedef enum logic [1:0] {LOAD, COMPUTE, DRAIN} state_e;

  state_e             state_q, state_d;
  logic               run_q;
  logic [DW-1:0]      vec_q [COLS];
  logic [DW-1:0]      vec_d [COLS];
  logic [VIW-1:0]     vidx_q, vidx_d;
  logic [BTW-1:0]     beat_q, beat_d;
  logic [RW-1:0]      row_q, row_d;
  logic [OW-1:0]      acc_q, acc_d;
  logic [OW-1:0]      tdata_q, tdata_d;
  logic               tvalid_q, tvalid_d;
  logic               tlast_q, tlast_d;
  logic               err_q, err_d;

  logic               v_hs, s_hs, last_v, last_beat, last_row;
  logic [OW-1:0]      psum;
  logic [VIW-1:0]     vsel;

  function automatic logic [OW-1:0] ext(input logic [DW-1:0] x);
    if (SIGNED) return {{(OW-DW){x[DW-1]}}, x};
    else        return {{(OW-DW){1'b0}}, x};
  endfunction

  assign v_hs      = v_axis_tvalid && v_axis_tready;
  assign s_hs      = s_axis_tvalid && s_axis_tready;
  assign last_v    = (vidx_q == VIW'(COLS-1));
  assign last_beat = (beat_q == BTW'(BEATS-1));
  assign last_row  = (row_q == RW'(ROWS-1));

  // Sign/zero extension to OW before multiplying keeps the sum exact modulo 2^OW.
  always_comb begin
    psum = '0;
    vsel = '0;
    for (int unsigned k = 0; k < LANES; k++) begin
      vsel = VIW'(beat_q * LANES + k);
      psum = psum + ext(s_axis_tdata[k*DW +: DW]) * ext(vec_q[vsel]);
    end
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      state_q <= LOAD;
      run_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      run_q   <= 1'b1;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      LOAD:    if (v_hs && last_v) state_d = COMPUTE;
      COMPUTE: if (s_hs && last_beat && last_row && !reuse_vec) state_d = DRAIN;
      DRAIN:   if (!tvalid_q || m_axis_tready) state_d = LOAD;
      default: state_d = LOAD;
    endcase
  end

  // run_q holds the vector port closed until the first edge after reset release.
  always_comb begin
    v_axis_tready = run_q && (state_q == LOAD);
    s_axis_tready = (state_q == COMPUTE) && (!tvalid_q || m_axis_tready);
  end

  always_comb begin
    vec_d    = vec_q;
    vidx_d   = vidx_q;
    beat_d   = beat_q;
    row_d    = row_q;
    acc_d    = acc_q;
    tdata_d  = tdata_q;
    tvalid_d = tvalid_q;
    tlast_d  = tlast_q;
    err_d    = err_q;
    if (v_hs) begin
      vec_d[vidx_q] = v_axis_tdata;
      vidx_d        = last_v ? '0 : vidx_q + 1'b1;
    end
    if (m_axis_tready) tvalid_d = 1'b0;
    if (s_hs) begin
      if (s_axis_tlast != last_beat) err_d = 1'b1;
      if (last_beat) begin
        tdata_d  = acc_q + psum;
        tvalid_d = 1'b1;
        tlast_d  = last_row;
        acc_d    = '0;
        beat_d   = '0;
        row_d    = last_row ? '0 : row_q + 1'b1;
      end else begin
        acc_d  = acc_q + psum;
        beat_d = beat_q + 1'b1;
      end
    end
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      vec_q    <= '{default: '0};
      vidx_q   <= '0;
      beat_q   <= '0;
      row_q    <= '0;
      acc_q    <= '0;
      tdata_q  <= '0;
      tvalid_q <= 1'b0;
      tlast_q  <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      vec_q    <= vec_d;
      vidx_q   <= vidx_d;
      beat_q   <= beat_d;
      row_q    <= row_d;
      acc_q    <= acc_d;
      tdata_q  <= tdata_d;
      tvalid_q <= tvalid_d;
      tlast_q  <= tlast_d;
      err_q    <= err_d;
    end
  end

  assign m_axis_tdata  = tdata_q;
  assign m_axis_tvalid = tvalid_q;
  assign m_axis_tlast  = tlast_q;
  assign err           = err_q;

endmodule

// File: tb/tb_mat_vect_mult_par.sv
// Bench for mat_vect_mult_par: an unsigned 2x4 instance and a signed 1x4 instance,
// with expected results queued at stimulus time and checked as results are consumed.
module tb_mat_vect_mult_par;

  logic        aclk = 1'b0;
  logic        aresetn = 1'b0;
  logic [7:0]  v_tdata  [2];
  logic        v_tvalid [2];
  logic [15:0] s_tdata  [2];
  logic        s_tvalid [2];
  logic        s_tlast  [2];
  logic        m_tready [2];
  logic        reuse    [2];

  logic        v_rdy0, s_rdy0, m_val0, m_last0, err0;
  logic        v_rdy1, s_rdy1, m_val1, m_last1, err1;
  logic [17:0] m_data0, m_data1;

  typedef struct packed { logic [17:0] d; logic l; } exp_t;
  exp_t q0[$];
  exp_t q1[$];

  int unsigned pass_cnt = 0;
  int unsigned total_cnt = 0;

  always #5 aclk = ~aclk;

  mat_vect_mult_par #(.ROWS(2), .COLS(4), .LANES(2), .DW(8), .SIGNED(1'b0)) dut_u (
    .aclk(aclk), .aresetn(aresetn),
    .v_axis_tdata(v_tdata[0]), .v_axis_tvalid(v_tvalid[0]), .v_axis_tready(v_rdy0),
    .s_axis_tdata(s_tdata[0]), .s_axis_tvalid(s_tvalid[0]), .s_axis_tlast(s_tlast[0]),
    .s_axis_tready(s_rdy0),
    .m_axis_tdata(m_data0), .m_axis_tvalid(m_val0), .m_axis_tlast(m_last0),
    .m_axis_tready(m_tready[0]), .reuse_vec(reuse[0]), .err(err0)
  );

  mat_vect_mult_par #(.ROWS(1), .COLS(4), .LANES(2), .DW(8), .SIGNED(1'b1)) dut_s (
    .aclk(aclk), .aresetn(aresetn),
    .v_axis_tdata(v_tdata[1]), .v_axis_tvalid(v_tvalid[1]), .v_axis_tready(v_rdy1),
    .s_axis_tdata(s_tdata[1]), .s_axis_tvalid(s_tvalid[1]), .s_axis_tlast(s_tlast[1]),
    .s_axis_tready(s_rdy1),
    .m_axis_tdata(m_data1), .m_axis_tvalid(m_val1), .m_axis_tlast(m_last1),
    .m_axis_tready(m_tready[1]), .reuse_vec(reuse[1]), .err(err1)
  );

  // Scoreboard: a result is consumed at the edge following a negedge with valid && ready.
  always @(negedge aclk) begin
    exp_t e;
    if (aresetn && m_val0 && m_tready[0]) begin
      total_cnt++;
      if (q0.size() == 0) $display("FAIL result_u: got unexpected %0h, expected no result", m_data0);
      else begin
        e = q0.pop_front();
        if (m_data0 !== e.d || m_last0 !== e.l)
          $display("FAIL result_u: got data %0h last %0b, expected data %0h last %0b", m_data0, m_last0, e.d, e.l);
        else pass_cnt++;
      end
    end
    if (aresetn && m_val1 && m_tready[1]) begin
      total_cnt++;
      if (q1.size() == 0) $display("FAIL result_s: got unexpected %0h, expected no result", m_data1);
      else begin
        e = q1.pop_front();
        if (m_data1 !== e.d || m_last1 !== e.l)
          $display("FAIL result_s: got data %0h last %0b, expected data %0h last %0b", m_data1, m_last1, e.d, e.l);
        else pass_cnt++;
      end
    end
  end

  task automatic load_vec(input int sel, input logic [31:0] vec);
    logic hs;
    int unsigned n;
    for (int i = 0; i < 4; i++) begin
      v_tdata[sel] = vec[i*8 +: 8];
      v_tvalid[sel] = 1'b1;
      hs = 1'b0; n = 0;
      while (!hs && n < 100) begin
        @(negedge aclk); hs = sel ? v_rdy1 : v_rdy0;
        @(posedge aclk); #1; n++;
      end
      v_tvalid[sel] = 1'b0;
      total_cnt++;
      if (!hs) $display("FAIL v_handshake: got no accept, expected accept within 100 cycles");
      else pass_cnt++;
    end
  endtask

  task automatic send_row(input int sel, input logic [31:0] row, input logic [17:0] exp_d,
                          input logic exp_l, input logic rv, input logic bad_tlast);
    logic hs;
    int unsigned n;
    exp_t e;
    reuse[sel] = rv;
    for (int b = 0; b < 2; b++) begin
      if (b == 1) begin
        e.d = exp_d; e.l = exp_l;
        if (sel) q1.push_back(e); else q0.push_back(e);
      end
      s_tdata[sel]  = row[b*16 +: 16];
      s_tlast[sel]  = (b == 1) || (bad_tlast && b == 0);
      s_tvalid[sel] = 1'b1;
      hs = 1'b0; n = 0;
      while (!hs && n < 100) begin
        @(negedge aclk); hs = sel ? s_rdy1 : s_rdy0;
        @(posedge aclk); #1; n++;
      end
      s_tvalid[sel] = 1'b0;
      s_tlast[sel]  = 1'b0;
      total_cnt++;
      if (!hs) $display("FAIL s_handshake: got no accept, expected accept within 100 cycles");
      else pass_cnt++;
    end
    reuse[sel] = 1'b0;
  endtask

  task automatic wait_empty(input int sel);
    int unsigned n = 0;
    while ((sel ? q1.size() : q0.size()) != 0 && n < 100) begin
      @(posedge aclk); #1; n++;
    end
    total_cnt++;
    if ((sel ? q1.size() : q0.size()) != 0)
      $display("FAIL drain: got %0d pending results, expected 0", sel ? q1.size() : q0.size());
    else pass_cnt++;
  endtask

  task automatic test_reset();
    #12;
    total_cnt++; if (v_rdy0 !== 1'b0) $display("FAIL rst_v_ready: got %b expected 0", v_rdy0); else pass_cnt++;
    total_cnt++; if (s_rdy0 !== 1'b0) $display("FAIL rst_s_ready: got %b expected 0", s_rdy0); else pass_cnt++;
    total_cnt++; if (m_val0 !== 1'b0) $display("FAIL rst_m_valid: got %b expected 0", m_val0); else pass_cnt++;
    total_cnt++; if (m_last0 !== 1'b0) $display("FAIL rst_m_last: got %b expected 0", m_last0); else pass_cnt++;
    total_cnt++; if (m_data0 !== 18'h0) $display("FAIL rst_m_data: got %0h expected 0", m_data0); else pass_cnt++;
    total_cnt++; if (err0 !== 1'b0) $display("FAIL rst_err: got %b expected 0", err0); else pass_cnt++;
    total_cnt++; if (v_rdy1 !== 1'b0) $display("FAIL rst_v_ready_s: got %b expected 0", v_rdy1); else pass_cnt++;
    #10 aresetn = 1'b1;
    @(posedge aclk); #1;
    total_cnt++; if (v_rdy0 !== 1'b1) $display("FAIL rel_v_ready: got %b expected 1", v_rdy0); else pass_cnt++;
    total_cnt++; if (v_rdy1 !== 1'b1) $display("FAIL rel_v_ready_s: got %b expected 1", v_rdy1); else pass_cnt++;
  endtask

  task automatic test_basic();
    load_vec(0, 32'h04030201);
    total_cnt++; if (s_rdy0 !== 1'b1) $display("FAIL s_ready_after_load: got %b expected 1", s_rdy0); else pass_cnt++;
    total_cnt++; if (v_rdy0 !== 1'b0) $display("FAIL v_ready_compute: got %b expected 0", v_rdy0); else pass_cnt++;
    send_row(0, 32'h01010101, 18'd10, 1'b0, 1'b0, 1'b0);
    send_row(0, 32'h01000002, 18'd6,  1'b1, 1'b0, 1'b0);
    wait_empty(0);
    @(posedge aclk); #1;
    total_cnt++; if (v_rdy0 !== 1'b1) $display("FAIL basic_back_to_load: got %b expected 1", v_rdy0); else pass_cnt++;
    total_cnt++; if (err0 !== 1'b0) $display("FAIL basic_err: got %b expected 0", err0); else pass_cnt++;
  endtask

  task automatic test_width();
    load_vec(0, 32'hFFFFFFFF);
    send_row(0, 32'hFFFFFFFF, 18'h3F804, 1'b0, 1'b0, 1'b0);
    send_row(0, 32'hFFFFFFFF, 18'h3F804, 1'b1, 1'b0, 1'b0);
    wait_empty(0);
  endtask

  task automatic test_backpressure();
    load_vec(0, 32'h04030201);
    m_tready[0] = 1'b0;
    send_row(0, 32'h01010101, 18'd10, 1'b0, 1'b0, 1'b0);
    total_cnt++; if (m_val0 !== 1'b1) $display("FAIL bp_valid: got %b expected 1", m_val0); else pass_cnt++;
    total_cnt++; if (s_rdy0 !== 1'b0) $display("FAIL bp_s_ready: got %b expected 0", s_rdy0); else pass_cnt++;
    repeat (3) @(posedge aclk);
    #1;
    total_cnt++; if (m_data0 !== 18'd10) $display("FAIL bp_hold_data: got %0d expected 10", m_data0); else pass_cnt++;
    total_cnt++; if (s_rdy0 !== 1'b0) $display("FAIL bp_s_ready_held: got %b expected 0", s_rdy0); else pass_cnt++;
    m_tready[0] = 1'b1;
    send_row(0, 32'h01000002, 18'd6, 1'b1, 1'b0, 1'b0);
    wait_empty(0);
  endtask

  task automatic test_reuse_err();
    load_vec(0, 32'h04030201);
    send_row(0, 32'h01010101, 18'd10, 1'b0, 1'b0, 1'b0);
    send_row(0, 32'h01000002, 18'd6,  1'b1, 1'b1, 1'b0);
    total_cnt++; if (v_rdy0 !== 1'b0) $display("FAIL reuse_v_ready: got %b expected 0", v_rdy0); else pass_cnt++;
    total_cnt++; if (s_rdy0 !== 1'b1) $display("FAIL reuse_s_ready: got %b expected 1", s_rdy0); else pass_cnt++;
    total_cnt++; if (err0 !== 1'b0) $display("FAIL reuse_err_before: got %b expected 0", err0); else pass_cnt++;
    send_row(0, 32'h02010003, 18'd14, 1'b0, 1'b0, 1'b1);
    total_cnt++; if (err0 !== 1'b1) $display("FAIL tlast_err_set: got %b expected 1", err0); else pass_cnt++;
    total_cnt++; if (v_rdy0 !== 1'b0) $display("FAIL reuse_v_ready_m2: got %b expected 0", v_rdy0); else pass_cnt++;
    send_row(0, 32'h00000500, 18'd10, 1'b1, 1'b0, 1'b0);
    wait_empty(0);
    repeat (2) @(posedge aclk);
    #1;
    total_cnt++; if (err0 !== 1'b1) $display("FAIL tlast_err_sticky: got %b expected 1", err0); else pass_cnt++;
    total_cnt++; if (v_rdy0 !== 1'b1) $display("FAIL reuse_back_to_load: got %b expected 1", v_rdy0); else pass_cnt++;
  endtask

  task automatic test_reset_mid_row();
    logic hs;
    int unsigned n;
    load_vec(0, 32'h04030201);
    s_tdata[0] = 16'h0909; s_tlast[0] = 1'b0; s_tvalid[0] = 1'b1;
    hs = 1'b0; n = 0;
    while (!hs && n < 100) begin
      @(negedge aclk); hs = s_rdy0;
      @(posedge aclk); #1; n++;
    end
    s_tvalid[0] = 1'b0;
    total_cnt++; if (!hs) $display("FAIL mid_handshake: got no accept, expected accept"); else pass_cnt++;
    #2 aresetn = 1'b0;
    #1;
    total_cnt++; if (v_rdy0 !== 1'b0) $display("FAIL mid_v_ready: got %b expected 0", v_rdy0); else pass_cnt++;
    total_cnt++; if (s_rdy0 !== 1'b0) $display("FAIL mid_s_ready: got %b expected 0", s_rdy0); else pass_cnt++;
    total_cnt++; if (m_val0 !== 1'b0) $display("FAIL mid_m_valid: got %b expected 0", m_val0); else pass_cnt++;
    total_cnt++; if (m_last0 !== 1'b0) $display("FAIL mid_m_last: got %b expected 0", m_last0); else pass_cnt++;
    total_cnt++; if (m_data0 !== 18'h0) $display("FAIL mid_m_data: got %0h expected 0", m_data0); else pass_cnt++;
    total_cnt++; if (err0 !== 1'b0) $display("FAIL mid_err: got %b expected 0", err0); else pass_cnt++;
    @(posedge aclk); #3 aresetn = 1'b1;
    @(posedge aclk); #1;
    load_vec(0, 32'h04030201);
    send_row(0, 32'h01010101, 18'd10, 1'b0, 1'b0, 1'b0);
    send_row(0, 32'h01000002, 18'd6,  1'b1, 1'b0, 1'b0);
    wait_empty(0);
  endtask

  task automatic test_signed();
    load_vec(1, 32'h04FD02FF);
    send_row(1, 32'h0807FA05, 18'h3FFFA, 1'b1, 1'b0, 1'b0);
    wait_empty(1);
    @(posedge aclk); #1;
    total_cnt++; if (v_rdy1 !== 1'b1) $display("FAIL signed_back_to_load: got %b expected 1", v_rdy1); else pass_cnt++;
    total_cnt++; if (err1 !== 1'b0) $display("FAIL signed_err: got %b expected 0", err1); else pass_cnt++;
  endtask

  initial begin
    for (int i = 0; i < 2; i++) begin
      v_tdata[i] = '0; v_tvalid[i] = 1'b0;
      s_tdata[i] = '0; s_tvalid[i] = 1'b0; s_tlast[i] = 1'b0;
      m_tready[i] = 1'b1; reuse[i] = 1'b0;
    end
    test_reset();
    test_basic();
    test_width();
    test_backpressure();
    test_reuse_err();
    test_reset_mid_row();
    test_signed();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got no completion, expected finish before 500000 time units");
    $fatal(1);
  end

endmodule
